mlp_job_arbiter: RTL
====================

# mlp_job_arbiter

Round-robin scheduler that shares one MLP accelerator instance (the `top` block: `init`, `inputs`, `ready`, `outputs`) among R independent requesters. Each requester submits an N-word input vector over a valid/ready handshake. The arbiter launches one inference at a time, watches for completion with a watchdog, and returns the output vector tagged with the requester ID over a response handshake. It sits between the system interconnect and the MLP top, and owns the MLP's `init` and reset pins.

## Interface
- `WORD_SIZE`, 8, datapath word width; must match the MLP.
- `N`, 2, neurons per layer, i.e. words per input and output vector.
- `R`, 4, number of requesters; R ≥ 2. `IDW` = $clog2(R).
- `TIMEOUT`, 255, watchdog limit in WAIT cycles; 0 disables the watchdog.
- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  R  per-requester request valid.
- `req_data`  in  R*N*WORD_SIZE  requester r occupies bits [(r+1)*N*WORD_SIZE-1 : r*N*WORD_SIZE]; word j of that slice is input j.
- `req_ready`  out  R  one-hot acceptance strobe; reset 0.
- `rsp_valid`  out  1  response valid; reset 0.
- `rsp_id`  out  IDW  requester that owns the response; reset 0.
- `rsp_data`  out  N*WORD_SIZE  MLP output vector, word j = output j; reset 0.
- `rsp_err`  out  1  response produced by watchdog timeout; reset 0.
- `rsp_ready`  in  1  consumer accepts the response.
- `mlp_init`  out  1  one-cycle start pulse to the MLP; reset 0.
- `mlp_inputs`  out  N*WORD_SIZE  input vector to the MLP; reset 0.
- `mlp_ready`  in  1  MLP completion pulse.
- `mlp_outputs`  in  N*WORD_SIZE  MLP result, valid while `mlp_ready` is high.
- `mlp_rst_n`  out  1  MLP reset, active-low; 0 while `n_rst` is low.
- `busy`  out  1  high in any state other than IDLE; reset 0.
- `job_count`  out  16  completed responses (both OK and error); wraps at 2^16; reset 0.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP. Reset state is IDLE. The round-robin pointer `rr_ptr` resets to 0.
- **IDLE arbitration:**
  - If any `req_valid` is high, grant g = the first set index scanning `rr_ptr`, `rr_ptr`+1, …, R-1, 0, …, wrapping.
  - `req_ready[g]` = 1 combinationally in that same cycle, so the handshake completes.
  - Latch `req_data` slice g into `mlp_inputs` and g into `rsp_id`, then go to LAUNCH.
  - `req_ready` is 0 in every other state and is never multi-hot.
- **LAUNCH:** `mlp_init` = 1 for exactly one cycle, then WAIT. `mlp_inputs` is registered and holds stable from LAUNCH until the next grant.
- **WAIT:** the timer counts from 0, incrementing each cycle.
  - If `mlp_ready` = 1: capture `mlp_outputs` into `rsp_data`, set `rsp_err` = 0, go to RESP.
  - Else, if `TIMEOUT` ≠ 0 and the timer reaches `TIMEOUT`: set `rsp_data` = 0 and `rsp_err` = 1, drive `mlp_rst_n` = 0 for exactly 2 cycles, go to RESP.
  - If `mlp_ready` and timeout occur in the same cycle, `mlp_ready` wins.
- **RESP:** `rsp_valid` = 1, with `rsp_id`, `rsp_data` and `rsp_err` held stable until `rsp_ready` is sampled high. On acceptance:
  - `rr_ptr` ← (`rsp_id` + 1) mod R;
  - `job_count` increments;
  - go to IDLE.
- `mlp_ready` outside WAIT is ignored.
- A `req_valid` that drops before it is granted is simply not accepted; nothing is recorded for it.
- `rsp_ready` held high early is legal; the response completes in the first RESP cycle.
- **Reset mid-job** (`n_rst` low in any state): all registers clear immediately, the in-flight job is discarded with no response, and `mlp_rst_n` goes 0.
- The timer is $clog2(TIMEOUT+1) bits wide and clears on entry to WAIT.

## Timing
- Cycle T: accept in IDLE (`req_ready` high). T+1: LAUNCH (`mlp_init` high). T+2: first WAIT cycle.
- If `mlp_ready` is sampled in WAIT at cycle C, `rsp_valid` is high from C+1.
- Minimum time from accept back to IDLE is 4 cycles (T: IDLE accept, T+1: LAUNCH, T+2: WAIT, T+3: RESP with `rsp_ready` high, IDLE at T+4). The earliest next accept is therefore T+4.
- **Timeout timing:** if WAIT is entered at cycle W with no `mlp_ready`, the timeout fires at W+`TIMEOUT`, `rsp_valid` rises at W+`TIMEOUT`+1, and `mlp_rst_n` is low for cycles W+`TIMEOUT`+1 and W+`TIMEOUT`+2.
- All outputs are registered except `req_ready`.

## Test plan
- Single request: R=4, requester 2 sends {0x03, 0x05}; the MLP model returns {0x11, 0x22} 6 cycles after `mlp_init`. Required: `req_ready`=0100 for 1 cycle, `mlp_init` pulse 1 cycle later, then `rsp_id`=2, `rsp_data`={0x11, 0x22}, `rsp_err`=0, `job_count`=1.
- Fairness: all 4 `req_valid` held high for 8 jobs. Grant order must be 0,1,2,3,0,1,2,3, with exactly one `req_ready` bit per job.
- Wrap: `rr_ptr`=3 with only requesters 3 and 0 valid. Required order is 3, then 0.
- Back-pressure: hold `rsp_ready`=0 for 10 cycles in RESP. `rsp_*` stays stable, no new `req_ready` is issued, and `job_count` does not change until the handshake completes.
- Watchdog: `TIMEOUT`=8 with the MLP model never asserting `mlp_ready`. Required: `rsp_err`=1, `rsp_data`=0, `mlp_rst_n` low for 2 cycles, and `rsp_valid` high exactly 9 cycles after WAIT entry. A subsequent job then completes normally.
- Reset mid-WAIT: drop `n_rst` 3 cycles into WAIT. All outputs return to their reset values, no response is produced, and after release a fresh request is granted starting from `rr_ptr`=0.

Source files
------------

// File: rtl/mlp_job_arbiter.sv
// Round-robin job arbiter sharing one MLP accelerator among R requesters.
// Launches one inference at a time, guards it with a watchdog, and returns ID-tagged results.
//
// state  | meaning
// IDLE   | arbitrate; grant one requester and latch its input vector
// LAUNCH | pulse mlp_init for one cycle
// WAIT   | wait for mlp_ready or watchdog expiry
// RESP   | present the response until rsp_ready
module mlp_job_arbiter #(
  parameter int WORD_SIZE = 8,
  parameter int N         = 2,
  parameter int R         = 4,
  parameter int TIMEOUT   = 255,
  localparam int IDW      = $clog2(R),
  localparam int VW       = N * WORD_SIZE
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [R-1:0]     req_valid,
  input  logic [R*VW-1:0]  req_data,
  output logic [R-1:0]     req_ready,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [VW-1:0]    rsp_data,
  output logic             rsp_err,
  input  logic             rsp_ready,
  output logic             mlp_init,
  output logic [VW-1:0]    mlp_inputs,
  input  logic             mlp_ready,
  input  logic [VW-1:0]    mlp_outputs,
  output logic             mlp_rst_n,
  output logic             busy,
  output logic [15:0]      job_count
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t         state, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [TW-1:0]  timer;
  logic           rst_hold;
  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic           tmo_fire;
  int             scan;

  // Rotating priority scan starting at rr_ptr; the first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = 0;
    for (int i = 0; i < R; i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= R) scan = scan - R;
      if (!grant_any && req_valid[scan]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(scan);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state;
    tmo_fire = 1'b0;
    case (state)
      S_IDLE:   if (grant_any) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (mlp_ready) begin
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && timer == TIMEOUT_T) begin
          tmo_fire = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      timer      <= '0;
      rst_hold   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      mlp_init   <= 1'b0;
      mlp_inputs <= '0;
      mlp_rst_n  <= 1'b0;
      busy       <= 1'b0;
      job_count  <= '0;
    end else begin
      state     <= state_d;
      busy      <= (state_d != S_IDLE);
      mlp_init  <= (state == S_IDLE) && grant_any;
      // Watchdog expiry holds the MLP in reset for two cycles.
      mlp_rst_n <= !(tmo_fire || rst_hold);
      rst_hold  <= tmo_fire;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            mlp_inputs <= req_data[grant_idx*VW +: VW];
            rsp_id     <= grant_idx;
          end
        end
        S_LAUNCH: timer <= '0;
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (mlp_ready) begin
            rsp_data  <= mlp_outputs;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end else if (tmo_fire) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (rsp_id == IDW'(R - 1)) ? '0 : rsp_id + 1'b1;
            job_count <= job_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
